fpu_mul_result_stage: RTL and testbench
=======================================

// Module: fpu_mul_result_stage
// PURPOSE
//  Final stage of the FPU multiplier, directly downstream of the special-case select unit.
//  Applies the 2-bit exponent/mantissa select codes, overflow and underflow to the computed product.
//  Packs the IEEE-754 result into an output register behind a valid/ready skid buffer (FULL-state skid register).
//  The downstream consumer (FFT butterfly adder) may stall without dropping results.
// PARAMETERS
//  SIZE_EXP  8   exponent width
//  SIZE_MAN  24  mantissa width incl. hidden bit; packed fraction is SIZE_MAN-1
// PORTS
//  i_clk       in   1                    clock, rising edge
//  i_rst       in   1                    asynchronous, active-high reset
//  i_valid     in   1                    upstream beat valid
//  o_ready     out  1                    stage can accept a beat
//  i_sign_a    in   1                    sign of operand A
//  i_sign_b    in   1                    sign of operand B
//  i_sel_exp   in   2                    exponent select code
//  i_sel_man   in   2                    mantissa select code
//  i_exp_calc  in   SIZE_EXP             normalised computed exponent
//  i_man_calc  in   SIZE_MAN-1           normalised computed fraction (hidden bit dropped)
//  i_ovf       in   1                    computed exponent overflowed
//  i_unf       in   1                    computed exponent underflowed
//  o_valid     out  1                    o_result valid
//  i_ready     in   1                    downstream accepts o_result
//  o_result    out  1+SIZE_EXP+SIZE_MAN-1  {sign, exp, frac}
//  o_is_nan    out  1                    result is NaN
//  o_is_inf    out  1                    result is +/-inf
//  o_is_zero   out  1                    result is +/-0
// BEHAVIOUR
//  Select codes: exp 00 = computed, 10 = all-zeros, 11 = all-ones, 01 = reserved (treated as 00).
//  Select codes: man 00 = computed, 10 = zero fraction, 11 = qNaN fraction (MSB=1, rest 0), 01 = reserved (treated as 00).
//  Computed path (exp sel 00): i_ovf -> inf; else i_unf -> signed zero (flush, no denormals).
//  ovf has priority over unf.
//  Sign = sign_a ^ sign_b. A NaN result always has sign 0.
//  Flags are decoded from the packed result: nan = exp all-ones & frac!=0, inf = exp all-ones & frac==0, zero = exp==0.
//  Handshake: a beat transfers when i_valid&o_ready (in) or o_valid&i_ready (out).
//  Latency: 1 cycle from accepted input to o_valid when empty.
//  States:
//   - EMPTY: out reg empty.
//   - ONE: out reg valid, skid empty.
//   - FULL: out reg and skid valid.
//  Transitions:
//   - EMPTY + in -> ONE.
//   - ONE + in & !out -> FULL (beat into skid).
//   - ONE + out & !in -> EMPTY.
//   - ONE + in & out -> ONE (beat into out reg).
//   - FULL + out -> ONE (skid moves to out reg).
//  o_ready = (state != FULL). It is registered: no combinational path from i_ready.
//  o_result, o_is_* stable while o_valid & !i_ready.
//  Reset: state EMPTY, o_valid=0, o_ready=1, o_result=0, all flags 0.
//  Reset asserted mid-transfer discards buffered beats.
//  Input beats with i_valid=1 while o_ready=0 are ignored; upstream must hold them.
// CONFIGURATION
//  FPU_MUL_STICKY_FLAGS_EN defined: adds ports i_flag_clr (in, 1) and o_sticky (out, 3) = {invalid, overflow, underflow}.
//   - Sticky bits set on each output transfer whose result is NaN / came from i_ovf / came from i_unf.
//   - Bits hold until i_flag_clr=1 for one cycle.
//   - Clear and set in the same cycle: set wins.
//   - Reset value 0.
//  Undefined: the two ports are absent and no sticky logic is present.
// STRUCTURE
//  Package fpu_mul_pkg holds:
//   - SEL_* localparams for the select codes.
//   - QNAN_FRAC constant.
//   - Skid state enum.
//   - Packed result struct {sign, exp, frac}.
//  One sub-module, fpu_mul_skid_buf (payload-width parameterised 2-entry valid/ready buffer).
//  Packing and flag decode stay in this module.
// TESTING
//  Normal product:
//   - sel 00/00, signs 0/1, exp_calc=0x80, man_calc=0x400000 -> 0xC0400000 one cycle later, flags 0.
//  Special codes:
//   - exp 11, man 11, signs 1/1 -> 0x7FC00000, o_is_nan=1.
//   - exp 11, man 10, signs 1/0 -> 0xFF800000, o_is_inf=1.
//  Overflow/underflow:
//   - sel 00, i_ovf=1 -> 0x7F800000.
//   - i_unf=1, signs 1/0 -> 0x80000000, o_is_zero=1.
//   - Both ovf and unf set -> inf.
//  Backpressure:
//   - i_ready=0 for 3 cycles with continuous i_valid -> o_ready drops after 2 beats.
//   - On i_ready=1, beats emerge in order; no loss or duplication.
//  Async reset:
//   - i_rst pulse while FULL -> o_valid=0, o_ready=1 immediately.
//   - Next accepted beat appears after 1 cycle.
//  Sticky flags (FPU_MUL_STICKY_FLAGS_EN defined):
//   - NaN beat -> o_sticky=3'b100, persists.
//   - i_flag_clr coincident with an ovf output transfer -> 3'b010.

Source files
------------

// File: rtl/fpu_mul_pkg.sv
// Shared types and constants for the FPU multiplier result stage.
// Select codes, quiet-NaN fraction, skid states and packed result layout.
package fpu_mul_pkg;

  localparam int EXP_W  = 8;
  localparam int MAN_W  = 24;
  localparam int FRAC_W = MAN_W - 1;

  localparam logic [1:0] SEL_CALC = 2'b00;
  localparam logic [1:0] SEL_RSVD = 2'b01;
  localparam logic [1:0] SEL_ZERO = 2'b10;
  localparam logic [1:0] SEL_ONES = 2'b11;

  localparam logic [FRAC_W-1:0] QNAN_FRAC =
    {1'b1, {(FRAC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    SKID_EMPTY,
    SKID_ONE,
    SKID_FULL
  } skid_state_t;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [FRAC_W-1:0] frac;
  } fp_result_t;

endpackage

// File: rtl/fpu_mul_skid_buf.sv
// Two-entry valid/ready buffer: output register plus one skid register.
// in_ready depends only on state, so there is no path from out_ready.
module fpu_mul_skid_buf
  import fpu_mul_pkg::*;
#(
  parameter int W = 35
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  skid_state_t state, state_nxt;
  logic [W-1:0] out_q, skid_q;
  logic in_fire, out_fire;
  logic load_out, load_skid, pop_skid;

  assign in_ready  = (state != SKID_FULL);
  assign out_valid = (state != SKID_EMPTY);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign out_data  = out_q;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= SKID_EMPTY;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load_out  = 1'b0;
    load_skid = 1'b0;
    pop_skid  = 1'b0;
    unique case (state)
      SKID_EMPTY: begin
        if (in_fire) begin
          state_nxt = SKID_ONE;
          load_out  = 1'b1;
        end
      end
      SKID_ONE: begin
        if (in_fire && !out_fire) begin
          state_nxt = SKID_FULL;
          load_skid = 1'b1;
        end else if (out_fire && !in_fire) begin
          state_nxt = SKID_EMPTY;
        end else if (in_fire && out_fire) begin
          load_out = 1'b1;
        end
      end
      SKID_FULL: begin
        if (out_fire) begin
          state_nxt = SKID_ONE;
          pop_skid  = 1'b1;
        end
      end
      default: state_nxt = SKID_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (load_out)      out_q <= in_data;
      else if (pop_skid) out_q <= skid_q;
      if (load_skid)     skid_q <= in_data;
    end
  end

endmodule

// File: rtl/fpu_mul_result_stage.sv
// FPU multiplier result stage: select/ovf/unf apply, pack, flag decode, skid out.
// FPU_MUL_STICKY_FLAGS_EN adds i_flag_clr and o_sticky {invalid, ovf, unf}.
module fpu_mul_result_stage
  import fpu_mul_pkg::*;
#(
  parameter int SIZE_EXP = EXP_W,
  parameter int SIZE_MAN = MAN_W
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_valid,
  output logic                         o_ready,
  input  logic                         i_sign_a,
  input  logic                         i_sign_b,
  input  logic [1:0]                   i_sel_exp,
  input  logic [1:0]                   i_sel_man,
  input  logic [SIZE_EXP-1:0]          i_exp_calc,
  input  logic [SIZE_MAN-2:0]          i_man_calc,
  input  logic                         i_ovf,
  input  logic                         i_unf,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic [SIZE_EXP+SIZE_MAN-1:0] o_result,
`ifdef FPU_MUL_STICKY_FLAGS_EN
  input  logic                         i_flag_clr,
  output logic [2:0]                   o_sticky,
`endif
  output logic                         o_is_nan,
  output logic                         o_is_inf,
  output logic                         o_is_zero
);

  localparam int RW = SIZE_EXP + SIZE_MAN;
`ifdef FPU_MUL_STICKY_FLAGS_EN
  localparam int PW = RW + 5;
`else
  localparam int PW = RW + 3;
`endif

  fp_result_t         res;
  logic [SIZE_EXP-1:0] exp_v;
  logic [SIZE_MAN-2:0] frac_v;
  logic exp_calc, ovf_hit, unf_hit;
  logic nan, inf, zero;
  logic [PW-1:0] pay_in, pay_out;

  // Overflow/underflow only act when the computed exponent is selected
  assign exp_calc = ~i_sel_exp[1];
  assign ovf_hit  = exp_calc & i_ovf;
  assign unf_hit  = exp_calc & ~i_ovf & i_unf;

  always_comb begin
    exp_v  = i_exp_calc;
    frac_v = i_man_calc;
    unique case (1'b1)
      ovf_hit: begin
        exp_v  = '1;
        frac_v = '0;
      end
      unf_hit: begin
        exp_v  = '0;
        frac_v = '0;
      end
      default: begin
        unique case (i_sel_exp)
          SEL_ZERO: exp_v = '0;
          SEL_ONES: exp_v = '1;
          default:  exp_v = i_exp_calc;
        endcase
        unique case (i_sel_man)
          SEL_ZERO: frac_v = '0;
          SEL_ONES: frac_v = QNAN_FRAC;
          default:  frac_v = i_man_calc;
        endcase
      end
    endcase
  end

  assign nan  = (&exp_v) & (|frac_v);
  assign inf  = (&exp_v) & ~(|frac_v);
  assign zero = ~(|exp_v);

  assign res.sign = (i_sign_a ^ i_sign_b) & ~nan;
  assign res.exp  = exp_v;
  assign res.frac = frac_v;

`ifdef FPU_MUL_STICKY_FLAGS_EN
  assign pay_in = {ovf_hit, unf_hit, nan, inf, zero, res};
`else
  assign pay_in = {nan, inf, zero, res};
`endif

  fpu_mul_skid_buf #(.W(PW)) u_skid (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .in_valid  (i_valid),
    .in_ready  (o_ready),
    .in_data   (pay_in),
    .out_valid (o_valid),
    .out_ready (i_ready),
    .out_data  (pay_out)
  );

  assign {o_is_nan, o_is_inf, o_is_zero, o_result} = pay_out[RW+2:0];

`ifdef FPU_MUL_STICKY_FLAGS_EN
  logic [2:0] sticky;
  logic [2:0] sticky_set;

  assign sticky_set = {3{o_valid & i_ready}} &
                      {o_is_nan, pay_out[PW-1], pay_out[PW-2]};

  // A set in the clearing cycle survives the clear
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) sticky <= '0;
    else       sticky <= (i_flag_clr ? 3'b000 : sticky) | sticky_set;
  end

  assign o_sticky = sticky;
`endif

endmodule

// File: tb/tb_fpu_mul_result_stage.sv
// Self-checking bench for fpu_mul_result_stage.
// Directed beats, backpressure, async reset and a randomized scoreboard run.
module tb_fpu_mul_result_stage;

  logic        i_clk;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic        i_sign_a;
  logic        i_sign_b;
  logic [1:0]  i_sel_exp;
  logic [1:0]  i_sel_man;
  logic [7:0]  i_exp_calc;
  logic [22:0] i_man_calc;
  logic        i_ovf;
  logic        i_unf;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_result;
  logic        o_is_nan;
  logic        o_is_inf;
  logic        o_is_zero;
`ifdef FPU_MUL_STICKY_FLAGS_EN
  logic        i_flag_clr;
  logic [2:0]  o_sticky;
  bit   [2:0]  st_m;
`endif

  fpu_mul_result_stage dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .i_sign_a   (i_sign_a),
    .i_sign_b   (i_sign_b),
    .i_sel_exp  (i_sel_exp),
    .i_sel_man  (i_sel_man),
    .i_exp_calc (i_exp_calc),
    .i_man_calc (i_man_calc),
    .i_ovf      (i_ovf),
    .i_unf      (i_unf),
    .o_valid    (o_valid),
    .i_ready    (i_ready),
    .o_result   (o_result),
`ifdef FPU_MUL_STICKY_FLAGS_EN
    .i_flag_clr (i_flag_clr),
    .o_sticky   (o_sticky),
`endif
    .o_is_nan   (o_is_nan),
    .o_is_inf   (o_is_inf),
    .o_is_zero  (o_is_zero)
  );

  typedef struct {
    bit [31:0] res;
    bit        nan;
    bit        inf;
    bit        zero;
    bit        ovf_s;
    bit        unf_s;
  } exp_t;

  exp_t q[$];
  int   total  = 0;
  int   passed = 0;
  bit   last_in_fire;

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // IEEE single-precision result from the select/ovf/unf rules
  function automatic exp_t model(bit sa, bit sb, bit [1:0] se,
                                 bit [1:0] sm, bit [7:0] ec,
                                 bit [22:0] mc, bit ovf, bit unf);
    exp_t m;
    int   e;
    int   f;
    bit   s;
    bit   computed;
    m = '{default: 0};
    computed = (se == 2'd0) || (se == 2'd1);
    s = sa ^ sb;
    if (computed && ovf) begin
      e = 255; f = 0; m.ovf_s = 1;
    end else if (computed && unf) begin
      e = 0; f = 0; m.unf_s = 1;
    end else begin
      e = (se == 2'd2) ? 0 : (se == 2'd3) ? 255 : int'(ec);
      f = (sm == 2'd2) ? 0 : (sm == 2'd3) ? (1 << 22) : int'(mc);
    end
    m.nan  = (e == 255) && (f != 0);
    m.inf  = (e == 255) && (f == 0);
    m.zero = (e == 0);
    if (m.nan) s = 0;
    m.res = 32'(s) * 32'h8000_0000 + 32'(e) * 32'h80_0000 + 32'(f);
    return m;
  endfunction

  task automatic set_beat(bit sa, bit sb, bit [1:0] se, bit [1:0] sm,
                          bit [7:0] ec, bit [22:0] mc,
                          bit ovf, bit unf);
    i_sign_a = sa; i_sign_b = sb;
    i_sel_exp = se; i_sel_man = sm;
    i_exp_calc = ec; i_man_calc = mc;
    i_ovf = ovf; i_unf = unf;
  endtask

  task automatic rand_beat();
    set_beat(1'($urandom), 1'($urandom), 2'($urandom),
             2'($urandom), 8'($urandom), 23'($urandom),
             $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0);
  endtask

  // One clock: predict transfers from occupancy, then check outputs
  task automatic tick();
    exp_t cur;
    bit   in_f;
    bit   out_f;
    cur   = model(i_sign_a, i_sign_b, i_sel_exp, i_sel_man,
                  i_exp_calc, i_man_calc, i_ovf, i_unf);
    in_f  = i_valid && (q.size() < 2);
    out_f = (q.size() > 0) && i_ready;
    @(posedge i_clk);
    #1;
`ifdef FPU_MUL_STICKY_FLAGS_EN
    st_m = i_flag_clr ? 3'b000 : st_m;
    if (out_f) st_m |= {q[0].nan, q[0].ovf_s, q[0].unf_s};
`endif
    if (out_f) void'(q.pop_front());
    if (in_f) q.push_back(cur);
    last_in_fire = in_f;
    chk("o_valid", 32'(o_valid), 32'(q.size() > 0));
    chk("o_ready", 32'(o_ready), 32'(q.size() < 2));
    if (q.size() > 0) begin
      chk("o_result", o_result, q[0].res);
      chk("o_is_nan", 32'(o_is_nan), 32'(q[0].nan));
      chk("o_is_inf", 32'(o_is_inf), 32'(q[0].inf));
      chk("o_is_zero", 32'(o_is_zero), 32'(q[0].zero));
    end
`ifdef FPU_MUL_STICKY_FLAGS_EN
    chk("o_sticky", 32'(o_sticky), 32'(st_m));
`endif
  endtask

  initial begin
    i_rst = 1'b1;
    i_valid = 1'b0;
    i_ready = 1'b1;
    set_beat(0, 0, 2'd0, 2'd0, 8'h00, 23'h0, 0, 0);
`ifdef FPU_MUL_STICKY_FLAGS_EN
    i_flag_clr = 1'b0;
    st_m = 3'b000;
`endif
    repeat (2) @(posedge i_clk);
    #1;
    chk("rst o_valid", 32'(o_valid), 32'd0);
    chk("rst o_ready", 32'(o_ready), 32'd1);
    chk("rst o_result", o_result, 32'd0);
    chk("rst flags", 32'({o_is_nan, o_is_inf, o_is_zero}), 32'd0);
    i_rst = 1'b0;

    // Directed beats, consumer always ready
    i_valid = 1'b1;
    set_beat(0, 1, 2'd0, 2'd0, 8'h80, 23'h40_0000, 0, 0);
    tick();
    chk("normal", o_result, 32'hC040_0000);
    chk("normal flags", 32'({o_is_nan, o_is_inf, o_is_zero}), 32'd0);
    set_beat(1, 1, 2'd3, 2'd3, 8'h12, 23'h1234, 0, 0);
    tick();
    chk("qnan", o_result, 32'h7FC0_0000);
    chk("qnan flag", 32'(o_is_nan), 32'd1);
    set_beat(1, 0, 2'd3, 2'd2, 8'h12, 23'h1234, 0, 0);
    tick();
    chk("neg inf", o_result, 32'hFF80_0000);
    chk("inf flag", 32'(o_is_inf), 32'd1);
    set_beat(0, 0, 2'd0, 2'd0, 8'h7F, 23'h5555, 1, 0);
    tick();
    chk("ovf", o_result, 32'h7F80_0000);
    set_beat(1, 0, 2'd0, 2'd0, 8'h01, 23'h5555, 0, 1);
    tick();
    chk("unf", o_result, 32'h8000_0000);
    chk("unf zero flag", 32'(o_is_zero), 32'd1);
    set_beat(0, 0, 2'd0, 2'd0, 8'h01, 23'h5555, 1, 1);
    tick();
    chk("ovf over unf", o_result, 32'h7F80_0000);
    set_beat(0, 1, 2'd1, 2'd1, 8'h81, 23'h00_0001, 0, 0);
    tick();
    chk("reserved sel", o_result, 32'hC080_0001);
    i_valid = 1'b0;
    tick();

    // Backpressure: three offered beats, third must be held
    i_ready = 1'b0;
    i_valid = 1'b1;
    set_beat(0, 0, 2'd0, 2'd0, 8'h10, 23'h1, 0, 0);
    tick();
    chk("bp ready after 1", 32'(o_ready), 32'd1);
    set_beat(0, 0, 2'd0, 2'd0, 8'h20, 23'h2, 0, 0);
    tick();
    chk("bp ready after 2", 32'(o_ready), 32'd0);
    set_beat(0, 0, 2'd0, 2'd0, 8'h30, 23'h3, 0, 0);
    tick();
    chk("bp hold", o_result, 32'h0800_0001);
    i_ready = 1'b1;
    tick();
    chk("bp order 2", o_result, 32'h1000_0002);
    tick();
    chk("bp order 3", o_result, 32'h1800_0003);
    i_valid = 1'b0;
    tick();
    chk("bp drained", 32'(o_valid), 32'd0);

    // Async reset while full
    i_ready = 1'b0;
    i_valid = 1'b1;
    rand_beat();
    tick();
    rand_beat();
    tick();
    i_valid = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    chk("arst o_valid", 32'(o_valid), 32'd0);
    chk("arst o_ready", 32'(o_ready), 32'd1);
    q.delete();
`ifdef FPU_MUL_STICKY_FLAGS_EN
    st_m = 3'b000;
`endif
    #1;
    i_rst = 1'b0;
    i_ready = 1'b1;
    i_valid = 1'b1;
    set_beat(1, 0, 2'd0, 2'd0, 8'h40, 23'h7, 0, 0);
    tick();
    chk("post rst beat", o_result, 32'hA000_0007);
    i_valid = 1'b0;
    tick();

`ifdef FPU_MUL_STICKY_FLAGS_EN
    i_valid = 1'b1;
    set_beat(0, 0, 2'd3, 2'd3, 8'h0, 23'h0, 0, 0);
    tick();
    i_valid = 1'b0;
    tick();
    chk("sticky nan", 32'(o_sticky), 32'd4);
    tick();
    chk("sticky holds", 32'(o_sticky), 32'd4);
    i_valid = 1'b1;
    set_beat(0, 0, 2'd0, 2'd0, 8'h0, 23'h0, 1, 0);
    tick();
    i_valid = 1'b0;
    i_flag_clr = 1'b1;
    tick();
    i_flag_clr = 1'b0;
    chk("sticky clr+set", 32'(o_sticky), 32'd2);
`endif

    // Randomized traffic; held beats stay stable until accepted
    last_in_fire = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if (!(i_valid && !last_in_fire)) begin
        i_valid = ($urandom_range(0, 3) != 0);
        rand_beat();
      end
      i_ready = ($urandom_range(0, 2) != 0);
`ifdef FPU_MUL_STICKY_FLAGS_EN
      i_flag_clr = ($urandom_range(0, 15) == 0);
`endif
      tick();
    end
    i_valid = 1'b0;
    i_ready = 1'b1;
`ifdef FPU_MUL_STICKY_FLAGS_EN
    i_flag_clr = 1'b0;
`endif
    repeat (3) tick();
    chk("final empty", 32'(q.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
